// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_pkg
//  Brief    : Shared crossbar types, limits and helpers.
//  Revision : 1.0  initial release
// ============================================================================
package xbar_pkg;

    localparam int XBAR_MAX_MASTERS = 16;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    function automatic logic [3:0] onehot2idx(input logic [XBAR_MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < XBAR_MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_slave_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_slave_arbiter_if
//  Brief    : Master request / slave handshake bundle for one slave port.
//  Revision : 1.0  initial release
// ============================================================================
interface xbar_slave_arbiter_if #(
    parameter int N_MASTERS = 4
) ();
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] req_last;
    logic                 s_ready;
    logic                 s_valid;
    logic                 s_last;
    logic [N_MASTERS-1:0] m_ready;
    logic [N_MASTERS-1:0] grnt;
    logic [IDX_W-1:0]     grnt_idx;
    logic                 grnt_valid;
    logic                 timeout_err;

    // Arbiter side
    modport slave (
        input  req, req_last, s_ready,
        output s_valid, s_last, m_ready, grnt, grnt_idx, grnt_valid, timeout_err
    );

    // Requesting masters / slave mux side
    modport master (
        output req, req_last, s_ready,
        input  s_valid, s_last, m_ready, grnt, grnt_idx, grnt_valid, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/xbar_slave_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin selector, searching upward from ptr+1.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = 2
) (
    input  wire logic [N_MASTERS-1:0] req,
    input  wire logic [IDX_W-1:0]     ptr,
    output logic      [IDX_W-1:0]     pick_idx,
    output logic                      pick_vld
);
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        // ptr itself is visited last, so the previous winner only repeats when alone
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(ptr) + k) % N_MASTERS;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/xbar_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xbar_slave_arbiter
//  Brief    : Round-robin, transaction-locked slave port arbiter with stall
//             watchdog. XBAR_ARB_STATS_EN adds per-master grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 15
`ifdef XBAR_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  wire logic          clk,
    input  wire logic          reset,
    xbar_slave_arbiter_if.slave bus
`ifdef XBAR_ARB_STATS_EN
    ,
    output logic [N_MASTERS*CNT_W-1:0] grant_cnt
`endif
);
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SCNT_W = $clog2(TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] grnt_q, grnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SCNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [IDX_W-1:0]     w_g;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_vld;
    logic                 w_beat;

    assign w_g    = IDX_W'(onehot2idx(XBAR_MAX_MASTERS'(grnt_q)));
    assign w_beat = (|grnt_q) & bus.req[w_g] & bus.s_ready;

    // While BUSY rr_ptr equals the owner, so one picker serves both IDLE and release
    rr_pick #(.N_MASTERS(N_MASTERS), .IDX_W(IDX_W)) u_rr_pick (
        .req      (bus.req),
        .ptr      (rr_ptr_q),
        .pick_idx (w_pick_idx),
        .pick_vld (w_pick_vld)
    );

    always_comb begin
        state_d       = state_q;
        grnt_d        = grnt_q;
        rr_ptr_d      = rr_ptr_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    state_d     = ARB_BUSY;
                    grnt_d      = N_MASTERS'(1) << w_pick_idx;
                    rr_ptr_d    = w_pick_idx;
                    stall_cnt_d = '0;
                end
            end
            ARB_BUSY: begin
                if (w_beat) begin
                    stall_cnt_d = '0;
                    if (bus.req_last[w_g]) begin
                        if (w_pick_vld) begin
                            grnt_d   = N_MASTERS'(1) << w_pick_idx;
                            rr_ptr_d = w_pick_idx;
                        end else begin
                            state_d = ARB_IDLE;
                            grnt_d  = '0;
                        end
                    end
                end else if (!bus.req[w_g]) begin
                    // rr_ptr is left on the revoked master so it drops to lowest priority
                    if (stall_cnt_q == SCNT_W'(TIMEOUT - 1)) begin
                        state_d       = ARB_IDLE;
                        grnt_d        = '0;
                        stall_cnt_d   = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            grnt_q        <= '0;
            rr_ptr_q      <= IDX_W'(N_MASTERS - 1);
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grnt_q        <= grnt_d;
            rr_ptr_q      <= rr_ptr_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.grnt        = grnt_q;
    assign bus.grnt_idx    = w_g;
    assign bus.grnt_valid  = |grnt_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.s_valid     = (|grnt_q) & bus.req[w_g];
    assign bus.s_last      = (|grnt_q) & bus.req_last[w_g];
    assign bus.m_ready     = grnt_q & {N_MASTERS{bus.s_ready}};

`ifdef XBAR_ARB_STATS_EN
    logic w_new_grant;
    assign w_new_grant = (grnt_d != '0) &&
                         ((state_q == ARB_IDLE) || (w_beat && bus.req_last[w_g]));

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_grant_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (w_new_grant && (rr_ptr_d == IDX_W'(i)) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_xbar_slave_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbar_slave_arbiter
//  Brief    : Directed and random checks of xbar_slave_arbiter against an
//             owner/priority model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xbar_slave_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter_if #(.N_MASTERS(N)) bus ();

`ifdef XBAR_ARB_STATS_EN
    logic [4*N-1:0] grant_cnt;
    xbar_slave_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .grant_cnt(grant_cnt));
`else
    xbar_slave_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    // Model: who owns the port (-1 = nobody), last winner, stall length, error pulse
    int m_owner, m_last_win, m_stall, m_terr;
    int n_owner, n_last_win, n_stall, n_terr;

    function automatic int next_after(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last_win = N - 1; m_stall = 0; m_terr = 0;
    endtask

    task automatic model_step();
        n_owner = m_owner; n_last_win = m_last_win; n_stall = m_stall; n_terr = 0;
        if (m_owner < 0) begin
            n_owner = next_after(bus.req, m_last_win);
            if (n_owner >= 0) begin
                n_last_win = n_owner;
                n_stall    = 0;
            end
        end else if (bus.req[m_owner]) begin
            if (bus.s_ready) begin
                n_stall = 0;
                if (bus.req_last[m_owner]) begin
                    n_owner = next_after(bus.req, m_owner);
                    if (n_owner >= 0) n_last_win = n_owner;
                end
            end
        end else begin
            n_stall = m_stall + 1;
            if (n_stall == TO) begin
                n_owner = -1;
                n_stall = 0;
                n_terr  = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
        chk("grnt",        32'(bus.grnt), 32'(eg));
        chk("grnt_idx",    32'(bus.grnt_idx), (m_owner < 0) ? 0 : m_owner);
        chk("grnt_valid",  32'(bus.grnt_valid), (m_owner < 0) ? 0 : 1);
        chk("timeout_err", 32'(bus.timeout_err), m_terr);
        chk("s_valid",     32'(bus.s_valid), (m_owner >= 0 && bus.req[m_owner]) ? 1 : 0);
        chk("s_last",      32'(bus.s_last), (m_owner >= 0 && bus.req_last[m_owner]) ? 1 : 0);
        chk("m_ready",     32'(bus.m_ready), bus.s_ready ? 32'(eg) : 0);
    endtask

    // Called at a negedge: apply inputs, check, advance one clock, land on the next negedge
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        bus.req = r; bus.req_last = l; bus.s_ready = rdy;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        m_owner = n_owner; m_last_win = n_last_win; m_stall = n_stall; m_terr = n_terr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req = '0; bus.req_last = '0; bus.s_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int order [5];
        logic [N-1:0] r, l;
        logic rdy;
        int mode;
        order = '{0, 1, 2, 3, 0};

        // Reset state and single master, three-beat transaction
        do_reset();
        chk("rst_grnt", 32'(bus.grnt), 0);
        chk("rst_terr", 32'(bus.timeout_err), 0);
        cycle(4'b0001, 4'b0000, 1'b1);
        chk("t1_grant_latency", 32'(bus.grnt), 32'h1);
        cycle(4'b0001, 4'b0000, 1'b1);
        cycle(4'b0001, 4'b0000, 1'b1);
        cycle(4'b0001, 4'b0001, 1'b1);
        chk("t1_sole_regrant", 32'(bus.grnt), 32'h1);

        // All request, single-beat transactions: strict rotation without bubbles
        do_reset();
        cycle(4'b1111, 4'b1111, 1'b1);
        chk("t2_first", 32'(bus.grnt_idx), order[0]);
        for (int i = 1; i < 5; i++) begin
            cycle(4'b1111, 4'b1111, 1'b1);
            chk("t2_order", 32'(bus.grnt_idx), order[i]);
            chk("t2_no_bubble", 32'(bus.grnt_valid), 1);
        end

        // Backpressure is not a stall
        do_reset();
        cycle(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(4'b0010, 4'b0000, 1'b0);
            chk("t3_hold", 32'(bus.grnt), 32'h2);
            chk("t3_no_terr", 32'(bus.timeout_err), 0);
        end

        // Watchdog revocation and loss of priority
        do_reset();
        cycle(4'b0100, 4'b0000, 1'b1);
        for (int i = 0; i < TO - 1; i++) cycle(4'b0000, 4'b0000, 1'b1);
        chk("t4_before_to_grnt", 32'(bus.grnt), 32'h4);
        chk("t4_before_to_terr", 32'(bus.timeout_err), 0);
        cycle(4'b0000, 4'b0000, 1'b1);
        chk("t4_terr", 32'(bus.timeout_err), 1);
        chk("t4_revoked", 32'(bus.grnt), 0);
        cycle(4'b0110, 4'b0000, 1'b0);
        chk("t4_next_owner", 32'(bus.grnt), 32'h2);
        chk("t4_terr_pulse", 32'(bus.timeout_err), 0);
        cycle(4'b0110, 4'b0000, 1'b0);

        // Asynchronous reset mid-transaction
        bus.req = 4'b0110; bus.s_ready = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.grnt), 32'h2);
        reset = 1'b1;
        #1;
        chk("t5_async_grnt", 32'(bus.grnt), 0);
        chk("t5_async_svalid", 32'(bus.s_valid), 0);
        chk("t5_async_mready", 32'(bus.m_ready), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(4'b1000, 4'b0000, 1'b1);
        chk("t5_after_reset", 32'(bus.grnt), 32'h8);

`ifdef XBAR_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 22; i++) cycle(4'b0001, 4'b0001, 1'b1);
        chk("t6_cnt_sat", 32'(grant_cnt[3:0]), 32'hF);
        chk("t6_cnt_other", 32'(grant_cnt[15:4]), 0);
`endif

        // Random bursts: dense traffic, sparse traffic (stalls), heavy backpressure
        do_reset();
        for (int b = 0; b < 120; b++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 20; c++) begin
                r   = N'($urandom);
                l   = N'($urandom);
                rdy = ($urandom_range(0, 3) != 0);
                if (mode == 1 && $urandom_range(0, 15) != 0) r = '0;
                if (mode == 2) rdy = ($urandom_range(0, 7) == 0);
                cycle(r, l, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
